// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StShift,
        StFin
    } state_e;

    localparam int unsigned SENTINEL_W = 8;
    localparam logic [SENTINEL_W-1:0] SENTINEL = 8'hA5;

    // Sentinel bit for 0-based position idx, MSB first.
    function automatic logic sentinel_bit(input logic [2:0] idx);
        return SENTINEL[3'd7 - idx];
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that turns accepted bitstream words into a stream of bits, MSB first.
module ccff_word_serializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              prefetch,
    input  logic              chain_last,
    input  logic              clear,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              issue,
    output logic              bit_out
);

    localparam int unsigned IDX_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  left_q, left_d;
    logic              full, word_end, accept;

    always_comb begin
        full     = (left_q != '0);
        word_end = (left_q == IDX_W'(1));
        issue    = active && full;
        bit_out  = word_q[WORD_W-1];
        // Accept while the last bit leaves so words stream without a bubble, but never once
        // the chain's final bit is going out.
        word_ready = !(issue && chain_last) &&
                     ((prefetch && !full) || (active && (!full || word_end)));
        accept = word_ready && word_valid;

        word_d = word_q;
        left_d = left_q;
        if (clear) begin
            left_d = '0;
        end else if (accept) begin
            word_d = word_data;
            left_d = IDX_W'(WORD_W);
        end else if (issue) begin
            word_d = word_q << 1;
            left_d = left_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            left_q <= '0;
        end else begin
            word_q <= word_d;
            left_q <= left_d;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words onto a configuration chain and gates its prog_clk shifts.
// Define CCFF_SENTINEL_CHECK_EN to add the A5 sentinel pre-shift and tail continuity check.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + WORD_W + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              check_fail,
    output logic [CNT_W-1:0]  shift_count
);

`ifdef CCFF_SENTINEL_CHECK_EN
    localparam int unsigned PRE_LEN = SENTINEL_W;
`else
    localparam int unsigned PRE_LEN = 0;
`endif
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN + PRE_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(SENTINEL_W - 1);

    state_e           state_q, state_d;
    logic             head_q, head_d;
    logic             shift_en_q, shift_en_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             active, prefetch, clear, chain_last, issue, bit_out;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk        (prog_clk),
        .rst_n      (prog_reset_n),
        .active     (active),
        .prefetch   (prefetch),
        .chain_last (chain_last),
        .clear      (clear),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .issue      (issue),
        .bit_out    (bit_out)
    );

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        shift_en_d = 1'b0;
        count_d    = count_q;
        done_d     = done_q;
        clear      = 1'b0;
        active     = 1'b0;
        prefetch   = 1'b0;
        chain_last = (count_q == LAST_SHIFT);
        case (state_q)
            StIdle: begin
                if (start) begin
                    done_d  = 1'b0;
                    count_d = '0;
                    clear   = 1'b1;
`ifdef CCFF_SENTINEL_CHECK_EN
                    state_d = StPre;
`else
                    state_d = StShift;
`endif
                end
            end
            StPre: begin
                // Sentinel goes first; the first data word is fetched meanwhile.
                prefetch   = 1'b1;
                head_d     = sentinel_bit(count_q[2:0]);
                shift_en_d = 1'b1;
                count_d    = count_q + CNT_W'(1);
                if (count_q == PRE_LAST) state_d = StShift;
            end
            StShift: begin
                active = 1'b1;
                if (issue) begin
                    head_d     = bit_out;
                    shift_en_d = 1'b1;
                    count_d    = count_q + CNT_W'(1);
                    if (chain_last) state_d = StFin;
                end
            end
            StFin: begin
                clear   = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= StIdle;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

`ifdef CCFF_SENTINEL_CHECK_EN
    localparam logic [CNT_W-1:0] FIRST_CHK = CNT_W'(CHAIN_LEN + 1);

    logic             fail_q, fail_d;
    logic [CNT_W-1:0] tail_off;

    // The tail seen at the edge applying shift n is the pre-shift value; shifts
    // CHAIN_LEN+1 onward return the sentinel.
    always_comb begin
        fail_d   = fail_q;
        tail_off = count_q - FIRST_CHK;
        if (state_q == StIdle && start) begin
            fail_d = 1'b0;
        end else if (shift_en_q && count_q >= FIRST_CHK &&
                     ccff_tail != sentinel_bit(tail_off[2:0])) begin
            fail_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) fail_q <= 1'b0;
        else               fail_q <= fail_d;
    end

    assign check_fail = fail_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign check_fail  = 1'b0;
`endif

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign shift_count   = count_q;

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Upstream feeder of a tile's configuration chain. Accepts bitstream words over a valid/ready interface and serializes them MSB-first onto ccff_head.
- Drives a shift-enable for the external ICG that gates the chain's prog_clk, and counts exactly CHAIN_LEN shifts.
- Optionally verifies chain continuity by watching a sentinel emerge at ccff_tail.

Parameters:
- CHAIN_LEN, 1024, number of configuration flops between ccff_head and ccff_tail (>=1).
- WORD_W, 8, bitstream word width.
- CNT_W, $clog2(CHAIN_LEN+WORD_W+1), shift-counter width (derived; do not override).

Ports:
- prog_clk  in  1  free-running configuration clock; all state on rising edge.
- prog_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- word_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word this cycle.
- ccff_head  out  1  serial data into the chain (registered).
- ccff_shift_en  out  1  registered enable to the chain's prog_clk ICG.
- ccff_tail  in  1  serial output of the chain.
- busy  out  1  load in progress.
- done  out  1  load complete; held until next start.
- check_fail  out  1  sentinel mismatch; held until next start.
- shift_count  out  CNT_W  shifts issued in the current load.

Behaviour:
- Reset (async, prog_reset_n=0): all outputs 0, state IDLE, word buffer empty, counters 0. Reset mid-load abandons the load. No done is produced; chain contents are undefined.
- Shift timing: ccff_head and ccff_shift_en are updated at edge k. The ICG applies the enable at edge k+1, so the chain captures ccff_head at k+1. At that same edge k+1 the loader samples ccff_tail, which is the pre-shift value.
- States:
  - IDLE: start=1 clears done, check_fail and shift_count, then goes to PRE if the feature is enabled, else to SHIFT.
  - PRE: feature only. Drives the 8-bit sentinel 8'hA5 MSB-first, one bit per cycle with ccff_shift_en=1, consuming no words. Goes to SHIFT after 8 bits.
  - SHIFT:
    - Data path: one-word buffer plus bit index. word_ready=1 when the buffer is empty, or when its last bit is being issued this cycle, so back-to-back words stream with no bubble.
    - Stall: if the buffer is empty and word_valid=0, ccff_shift_en=0 and ccff_head holds its value.
    - Each issued bit sets ccff_shift_en=1 and increments shift_count.
    - When data bits issued reach CHAIN_LEN, go to FIN. Remaining bits of the final word are discarded, and word_ready stays 0 from then on.
  - FIN: ccff_shift_en=0 for one cycle, which lets the last shift's tail sample land. Then busy=0, done=1, go to IDLE.
- busy=1 in every state except IDLE.
- start is ignored while busy.
- word_valid while idle is not accepted (word_ready=0).
- shift_count saturates at its final value: CHAIN_LEN, or CHAIN_LEN+8 with the feature.

Optional Feature:
- Macro: CCFF_SENTINEL_CHECK_EN.
- Defined:
  - PRE state is present. Total shifts = CHAIN_LEN+8.
  - The tail value sampled on shifts CHAIN_LEN+1 .. CHAIN_LEN+8 (1-based, sentinel-inclusive) must equal 8'hA5 MSB-first. Any mismatch sets check_fail, which is sticky until the next start.
  - When the load completes, the chain holds exactly the data bits.
- Undefined:
  - No PRE state; CHAIN_LEN shifts total.
  - check_fail is tied 0 and ccff_tail is unused.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum (IDLE, PRE, SHIFT, FIN);
  - the sentinel constant 8'hA5 and SENTINEL_W=8.
- One natural sub-module: ccff_word_serializer, which owns the word buffer, bit index, word_ready and bit-issue strobe. The FSM, counting and check logic stay in the top.

Test Plan:
- CHAIN_LEN=16, feature off, words 8'hC3, 8'h5A with valid held high → 16 consecutive ccff_shift_en cycles. Chain model holds 16'hC35A. done rises 1 cycle after the last shift; shift_count=16.
- CHAIN_LEN=12, words 8'hFF, 8'h0F → 12 shifts only. The low nibble of the second word is discarded, word_ready=0 afterwards, and the chain holds 12'hFF0.
- word_valid dropped for 5 cycles mid-load → ccff_shift_en=0 for those cycles, ccff_head stable. Final chain contents are unchanged versus the no-stall run.
- Feature on, CHAIN_LEN=16, ideal chain model → 24 shifts, check_fail=0, chain holds the data. Repeat with a stuck-at-0 tail → check_fail=1 and done=1.
- prog_reset_n pulsed low after 7 shifts → all outputs 0 immediately (asynchronous). A new start then performs a full clean load.
- start pulsed while busy → ignored; shift_count sequence is unaffected.
